rx_gasket_ctrl: RTL and testbench

Sequencing controller for the PHY RX byte-to-word packing gasket. It watches the 8-bit recovered symbol stream and its K flag, and acquires word alignment on COM symbols. It drives the per-lane write select and word-commit strobes that pack symbols into 8/16/32-bit words. It also removes SKP symbols and reports lock and alignment errors. It sits between the 8b/10b decoder and the gasket, entirely in the clk_to_get domain.

---
 rtl/rx_gasket_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_rx_gasket_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rx_gasket_ctrl.sv
// Sequencing controller for the PHY RX byte-to-word packing gasket: COM-based word
// alignment, lane write/commit strobes, SKP removal and lock/alignment error reporting.
module rx_gasket_ctrl #(
  parameter logic [7:0]  COM_SYM    = 8'hBC,
  parameter logic [7:0]  SKP_SYM    = 8'h1C,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned MAX_MISS   = 4
) (
  input  logic       clk_to_get,
  input  logic       Rst_n,
  input  logic       Rx_valid,
  input  logic       Rx_Datak,
  input  logic [7:0] Data_in,
  input  logic [5:0] width,
  output logic [1:0] lane_sel,
  output logic       lane_wr,
  output logic       word_commit,
  output logic [3:0] k_mask,
  output logic [5:0] width_eff,
  output logic       aligned,
  output logic       skp_drop,
  output logic       align_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned LW = 2;
  localparam int unsigned KW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned WW = 6;
  localparam int unsigned EW = 8;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] lc_q, lc_d;
  logic [CW-1:0] good_q, good_d;
  logic [CW-1:0] miss_q, miss_d;
  logic [KW-1:0] k_acc_q, k_acc_d;
  logic [WW-1:0] width_eff_q, width_eff_d;
  logic [LW-1:0] lane_sel_q, lane_sel_d;
  logic          lane_wr_q, lane_wr_d;
  logic          word_commit_q, word_commit_d;
  logic [KW-1:0] k_mask_q, k_mask_d;
  logic          aligned_q, aligned_d;
  logic          skp_drop_q, skp_drop_d;
  logic          align_err_q, align_err_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;

  logic          is_com_c, is_skp_c, width_ok_c;
  logic          do_write_c, restart_c;
  logic [LW-1:0] last_c, base_lc_c;
  logic [KW-1:0] base_acc_c, acc_new_c;

  function automatic logic [LW-1:0] last_lane(input logic [WW-1:0] w);
    case (w)
      6'd16:   last_lane = 2'd1;
      6'd32:   last_lane = 2'd3;
      default: last_lane = 2'd0;
    endcase
  endfunction

  assign is_com_c   = Rx_valid && Rx_Datak && (Data_in == COM_SYM);
  assign is_skp_c   = Rx_valid && Rx_Datak && (Data_in == SKP_SYM);
  assign width_ok_c = (width == 6'd8) || (width == 6'd16) || (width == 6'd32);

  always_ff @(posedge clk_to_get or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_UNLOCKED;
      lc_q          <= '0;
      good_q        <= '0;
      miss_q        <= '0;
      k_acc_q       <= '0;
      width_eff_q   <= 6'd8;
      lane_sel_q    <= '0;
      lane_wr_q     <= 1'b0;
      word_commit_q <= 1'b0;
      k_mask_q      <= '0;
      aligned_q     <= 1'b0;
      skp_drop_q    <= 1'b0;
      align_err_q   <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      lc_q          <= lc_d;
      good_q        <= good_d;
      miss_q        <= miss_d;
      k_acc_q       <= k_acc_d;
      width_eff_q   <= width_eff_d;
      lane_sel_q    <= lane_sel_d;
      lane_wr_q     <= lane_wr_d;
      word_commit_q <= word_commit_d;
      k_mask_q      <= k_mask_d;
      aligned_q     <= aligned_d;
      skp_drop_q    <= skp_drop_d;
      align_err_q   <= align_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lc_d          = lc_q;
    good_d        = good_q;
    miss_d        = miss_q;
    k_acc_d       = k_acc_q;
    width_eff_d   = width_eff_q;
    lane_sel_d    = '0;
    lane_wr_d     = 1'b0;
    word_commit_d = 1'b0;
    k_mask_d      = '0;
    skp_drop_d    = 1'b0;
    align_err_d   = 1'b0;
    err_cnt_d     = err_cnt_q;
    do_write_c    = 1'b0;
    restart_c     = 1'b0;

    // New width takes effect before the symbol of this cycle is placed
    if (width_ok_c && ((lc_q == '0) || (state_q == ST_UNLOCKED))) width_eff_d = width;
    last_c = last_lane(width_eff_d);

    if (Rx_valid) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (is_com_c) begin
            good_d    = CW'(1);
            restart_c = 1'b1;
            state_d   = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          if (is_skp_c) begin
            skp_drop_d = 1'b1;
          end else if (is_com_c && (lc_q != '0)) begin
            align_err_d = 1'b1;
            good_d      = CW'(1);
            restart_c   = 1'b1;
          end else begin
            do_write_c = 1'b1;
            if (is_com_c) begin
              good_d = good_q + CW'(1);
              if (good_d >= CW'(LOCK_COUNT)) state_d = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (is_skp_c) begin
            skp_drop_d = 1'b1;
          end else if (is_com_c && (lc_q != '0)) begin
            align_err_d = 1'b1;
            miss_d      = miss_q + CW'(1);
            if (miss_d >= CW'(MAX_MISS)) begin
              state_d = ST_UNLOCKED;
              lc_d    = '0;
              k_acc_d = '0;
              good_d  = '0;
              miss_d  = '0;
            end else begin
              restart_c = 1'b1;
            end
          end else begin
            do_write_c = 1'b1;
            if (is_com_c) miss_d = '0;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end

    // A restart discards the partial word and places the COM on lane 0
    base_lc_c  = restart_c ? '0 : lc_q;
    base_acc_c = restart_c ? '0 : k_acc_q;
    acc_new_c  = base_acc_c | (KW'(Rx_Datak) << base_lc_c);
    if (do_write_c || restart_c) begin
      lane_wr_d  = 1'b1;
      lane_sel_d = base_lc_c;
      if (base_lc_c == last_c) begin
        word_commit_d = 1'b1;
        k_mask_d      = acc_new_c;
        lc_d          = '0;
        k_acc_d       = '0;
      end else begin
        lc_d    = base_lc_c + LW'(1);
        k_acc_d = acc_new_c;
      end
    end

    aligned_d = (state_d == ST_LOCKED);
    if (align_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + EW'(1);
  end

  assign lane_sel    = lane_sel_q;
  assign lane_wr     = lane_wr_q;
  assign word_commit = word_commit_q;
  assign k_mask      = k_mask_q;
  assign width_eff   = width_eff_q;
  assign aligned     = aligned_q;
  assign skp_drop    = skp_drop_q;
  assign align_err   = align_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_rx_gasket_ctrl.sv
// Directed bench for rx_gasket_ctrl: each step presents one symbol and checks the
// registered response one cycle later against hand-computed values.
module tb_rx_gasket_ctrl;

  logic       clk_to_get;
  logic       Rst_n;
  logic       Rx_valid;
  logic       Rx_Datak;
  logic [7:0] Data_in;
  logic [5:0] width;
  logic [1:0] lane_sel;
  logic       lane_wr;
  logic       word_commit;
  logic [3:0] k_mask;
  logic [5:0] width_eff;
  logic       aligned;
  logic       skp_drop;
  logic       align_err;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  rx_gasket_ctrl dut (
    .clk_to_get (clk_to_get),
    .Rst_n      (Rst_n),
    .Rx_valid   (Rx_valid),
    .Rx_Datak   (Rx_Datak),
    .Data_in    (Data_in),
    .width      (width),
    .lane_sel   (lane_sel),
    .lane_wr    (lane_wr),
    .word_commit(word_commit),
    .k_mask     (k_mask),
    .width_eff  (width_eff),
    .aligned    (aligned),
    .skp_drop   (skp_drop),
    .align_err  (align_err),
    .err_cnt    (err_cnt)
  );

  initial clk_to_get = 1'b0;
  always #5 clk_to_get = ~clk_to_get;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one symbol, then land just after the edge that registers its response
  task automatic step(input logic v, input logic k, input logic [7:0] d);
    @(negedge clk_to_get);
    Rx_valid = v;
    Rx_Datak = k;
    Data_in  = d;
    @(posedge clk_to_get);
    #1;
  endtask

  task automatic wr_chk(input string tag, input logic wr, input logic [1:0] sel,
                        input logic cm, input logic [3:0] km);
    chk({tag, ".lane_wr"}, 32'(lane_wr), 32'(wr));
    if (wr) chk({tag, ".lane_sel"}, 32'(lane_sel), 32'(sel));
    chk({tag, ".word_commit"}, 32'(word_commit), 32'(cm));
    chk({tag, ".k_mask"}, 32'(k_mask), 32'(km));
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, ".lane_sel"}, 32'(lane_sel), 32'd0);
    chk({tag, ".lane_wr"}, 32'(lane_wr), 32'd0);
    chk({tag, ".word_commit"}, 32'(word_commit), 32'd0);
    chk({tag, ".k_mask"}, 32'(k_mask), 32'd0);
    chk({tag, ".width_eff"}, 32'(width_eff), 32'd8);
    chk({tag, ".aligned"}, 32'(aligned), 32'd0);
    chk({tag, ".skp_drop"}, 32'(skp_drop), 32'd0);
    chk({tag, ".align_err"}, 32'(align_err), 32'd0);
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    Rst_n    = 1'b0;
    Rx_valid = 1'b0;
    Rx_Datak = 1'b0;
    Data_in  = 8'h00;
    width    = 6'd32;
    repeat (3) @(posedge clk_to_get);
    #1;
    rst_chk("reset");
    @(negedge clk_to_get);
    Rst_n = 1'b1;

    // Acquisition at width 32
    step(1, 1, 8'hBC); wr_chk("acq0", 1, 2'd0, 0, 4'h0);
    chk("acq0.aligned", 32'(aligned), 32'd0);
    chk("acq0.width_eff", 32'(width_eff), 32'd32);
    step(1, 0, 8'h4A); wr_chk("acq1", 1, 2'd1, 0, 4'h0);
    step(1, 0, 8'h4A); wr_chk("acq2", 1, 2'd2, 0, 4'h0);
    step(1, 0, 8'h4A); wr_chk("acq3", 1, 2'd3, 1, 4'h1);
    step(1, 1, 8'hBC); wr_chk("acq4", 1, 2'd0, 0, 4'h0);
    chk("acq4.aligned", 32'(aligned), 32'd1);
    step(1, 0, 8'h4A); wr_chk("acq5", 1, 2'd1, 0, 4'h0);
    step(1, 0, 8'h4A); wr_chk("acq6", 1, 2'd2, 0, 4'h0);
    step(1, 0, 8'h4A); wr_chk("acq7", 1, 2'd3, 1, 4'h1);

    // SKP removal at width 16
    width = 6'd16;
    step(1, 1, 8'hBC); wr_chk("skp0", 1, 2'd0, 0, 4'h0);
    chk("skp0.width_eff", 32'(width_eff), 32'd16);
    step(1, 1, 8'h1C); wr_chk("skp1", 0, 2'd0, 0, 4'h0);
    chk("skp1.skp_drop", 32'(skp_drop), 32'd1);
    step(1, 0, 8'hD0); wr_chk("skp2", 1, 2'd1, 1, 4'h1);
    chk("skp2.skp_drop", 32'(skp_drop), 32'd0);

    // Width change mid-word waits for the word boundary; illegal width ignored
    step(1, 0, 8'h4A); wr_chk("wch0", 1, 2'd0, 0, 4'h0);
    width = 6'd32;
    step(1, 0, 8'h4A); wr_chk("wch1", 1, 2'd1, 1, 4'h0);
    chk("wch1.width_eff", 32'(width_eff), 32'd16);
    step(0, 0, 8'h00); wr_chk("wch2", 0, 2'd0, 0, 4'h0);
    chk("wch2.width_eff", 32'(width_eff), 32'd32);
    width = 6'd12;
    step(0, 0, 8'h00);
    chk("wch3.width_eff", 32'(width_eff), 32'd32);
    width = 6'd32;

    // Rx_valid gap mid-word holds the lane counter
    step(1, 0, 8'h11); wr_chk("gap0", 1, 2'd0, 0, 4'h0);
    step(1, 0, 8'h22); wr_chk("gap1", 1, 2'd1, 0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00); wr_chk("gapidle", 0, 2'd0, 0, 4'h0);
    end
    step(1, 0, 8'h33); wr_chk("gap2", 1, 2'd2, 0, 4'h0);
    step(1, 1, 8'hF7); wr_chk("gap3", 1, 2'd3, 1, 4'h8);

    // Misplaced COMs while locked: three are absorbed, the fourth drops lock
    step(1, 0, 8'h4A); wr_chk("mis0", 1, 2'd0, 0, 4'h0);
    step(1, 0, 8'h4A); wr_chk("mis1", 1, 2'd1, 0, 4'h0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, 8'hBC); wr_chk("misc", 1, 2'd0, 0, 4'h0);
      chk("misc.align_err", 32'(align_err), 32'd1);
      chk("misc.err_cnt", 32'(err_cnt), 32'(i));
      chk("misc.aligned", 32'(aligned), 32'd1);
    end
    step(1, 1, 8'hBC); wr_chk("misdrop", 0, 2'd0, 0, 4'h0);
    chk("misdrop.align_err", 32'(align_err), 32'd1);
    chk("misdrop.err_cnt", 32'(err_cnt), 32'd4);
    chk("misdrop.aligned", 32'(aligned), 32'd0);
    step(1, 0, 8'h4A); wr_chk("unlk", 0, 2'd0, 0, 4'h0);
    chk("unlk.align_err", 32'(align_err), 32'd0);

    // Relock, stop at lc=2, then async reset mid-word
    step(1, 1, 8'hBC); wr_chk("rl0", 1, 2'd0, 0, 4'h0);
    step(1, 0, 8'h4A);
    step(1, 0, 8'h4A);
    step(1, 0, 8'h4A); wr_chk("rl3", 1, 2'd3, 1, 4'h1);
    step(1, 1, 8'hBC); chk("rl4.aligned", 32'(aligned), 32'd1);
    step(1, 0, 8'h4A); wr_chk("rl5", 1, 2'd1, 0, 4'h0);
    @(negedge clk_to_get);
    Rst_n    = 1'b0;
    Rx_valid = 1'b0;
    #1;
    rst_chk("midrst");
    @(negedge clk_to_get);
    Rst_n = 1'b1;
    step(1, 1, 8'hBC); wr_chk("post", 1, 2'd0, 0, 4'h0);
    chk("post.aligned", 32'(aligned), 32'd0);
    chk("post.err_cnt", 32'(err_cnt), 32'd0);

    // Repeated misplaced COMs in LOCKING saturate the error counter
    for (int i = 0; i < 254; i++) step(1, 1, 8'hBC);
    chk("sat254.err_cnt", 32'(err_cnt), 32'd254);
    for (int i = 0; i < 46; i++) step(1, 1, 8'hBC);
    chk("sat300.err_cnt", 32'(err_cnt), 32'd255);
    chk("sat300.align_err", 32'(align_err), 32'd1);
    wr_chk("sat300", 1, 2'd0, 0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
